sram_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the shared 512K x 32 asynchronous external SRAM.
- Port A serves the M32632 IO bus (CPU). Port B serves a secondary master such as a host-side DMA/debug loader.
- Arbitrates between the ports round-robin and drives the SRAM strobes.
- Partial (byte-enable) writes are turned into read-modify-write sequences, so the SRAM is always written as a full 32-bit word.

---
 rtl/sram_arbiter_if.sv | 55 +++++
 rtl/sram_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the SRAM pads.
interface sram_arbiter_if;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  // Port A (CPU IO bus)
  logic              a_rd;
  logic              a_wr;
  logic [ADDR_W-1:0] a_addr;
  logic [BE_W-1:0]   a_be;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] a_rdata;
  logic              a_ready;

  // Port B (secondary master)
  logic              b_rd;
  logic              b_wr;
  logic [ADDR_W-1:0] b_addr;
  logic [BE_W-1:0]   b_be;
  logic [DATA_W-1:0] b_wdata;
  logic [DATA_W-1:0] b_rdata;
  logic              b_ready;

  logic              grant_b;

  // SRAM side
  logic              ram_cs_b;
  logic              ram_oe_b;
  logic              ram_wr_b;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dq_out;
  logic              ram_dq_oe;
  logic [DATA_W-1:0] ram_dq_in;

  modport master (
    output a_rd, a_wr, a_addr, a_be, a_wdata,
    input  a_rdata, a_ready,
    output b_rd, b_wr, b_addr, b_be, b_wdata,
    input  b_rdata, b_ready,
    input  grant_b,
    input  ram_cs_b, ram_oe_b, ram_wr_b, ram_addr, ram_dq_out, ram_dq_oe,
    output ram_dq_in
  );

  modport slave (
    input  a_rd, a_wr, a_addr, a_be, a_wdata,
    output a_rdata, a_ready,
    input  b_rd, b_wr, b_addr, b_be, b_wdata,
    output b_rdata, b_ready,
    output grant_b,
    output ram_cs_b, ram_oe_b, ram_wr_b, ram_addr, ram_dq_out, ram_dq_oe,
    input  ram_dq_in
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer for a 512K x 32 async SRAM.
// Partial writes become read-modify-write so the SRAM only sees full words.
module sram_arbiter #(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned WR_LAT     = 1,
  parameter int unsigned RMW_RD_LAT = 1,
  parameter int unsigned RMW_WR_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_b,
  sram_arbiter_if.slave bus
);

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_RMW_RD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              r_state,   w_state;
  logic [CNT_W-1:0]    r_lcount,  w_lcount;
  logic                r_cs_b,    w_cs_b;
  logic                r_oe_b,    w_oe_b;
  logic                r_wr_b,    w_wr_b;
  logic [ADDR_W-1:0]   r_addr,    w_addr;
  logic [DATA_W-1:0]   r_dq_out,  w_dq_out;
  logic                r_dq_oe,   w_dq_oe;
  logic                r_a_ready, w_a_ready;
  logic                r_b_ready, w_b_ready;
  logic [DATA_W-1:0]   r_a_rdata, w_a_rdata;
  logic [DATA_W-1:0]   r_b_rdata, w_b_rdata;
  logic                r_grant_b, w_grant_b;
  logic [BE_W-1:0]     r_be,      w_be;
  logic [DATA_W-1:0]   r_wdata,   w_wdata;

  // Winner selection for the IDLE accept
  logic                w_a_req;
  logic                w_b_req;
  logic                w_win_b;
  logic                w_sel_rd;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [BE_W-1:0]     w_sel_be;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [DATA_W-1:0]   w_merge;

  // State and registered outputs; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state   <= S_IDLE;
      r_lcount  <= '0;
      r_cs_b    <= 1'b1;
      r_oe_b    <= 1'b1;
      r_wr_b    <= 1'b1;
      r_addr    <= '0;
      r_dq_out  <= '0;
      r_dq_oe   <= 1'b0;
      r_a_ready <= 1'b0;
      r_b_ready <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
      r_grant_b <= 1'b1;
      r_be      <= '0;
      r_wdata   <= '0;
    end else begin
      r_state   <= w_state;
      r_lcount  <= w_lcount;
      r_cs_b    <= w_cs_b;
      r_oe_b    <= w_oe_b;
      r_wr_b    <= w_wr_b;
      r_addr    <= w_addr;
      r_dq_out  <= w_dq_out;
      r_dq_oe   <= w_dq_oe;
      r_a_ready <= w_a_ready;
      r_b_ready <= w_b_ready;
      r_a_rdata <= w_a_rdata;
      r_b_rdata <= w_b_rdata;
      r_grant_b <= w_grant_b;
      r_be      <= w_be;
      r_wdata   <= w_wdata;
    end
  end

  // Request muxing: on a tie the port not named by grant_b wins
  always_comb begin
    w_a_req     = bus.a_rd | bus.a_wr;
    w_b_req     = bus.b_rd | bus.b_wr;
    w_win_b     = w_b_req & (~w_a_req | ~r_grant_b);
    w_sel_rd    = w_win_b ? bus.b_rd    : bus.a_rd;
    w_sel_addr  = w_win_b ? bus.b_addr  : bus.a_addr;
    w_sel_be    = w_win_b ? bus.b_be    : bus.a_be;
    w_sel_wdata = w_win_b ? bus.b_wdata : bus.a_wdata;
  end

  // Per-lane merge of latched write data over the word read back from SRAM
  always_comb begin
    w_merge = bus.ram_dq_in;
    for (int n = 0; n < int'(BE_W); n++) begin
      if (r_be[n]) w_merge[n*8 +: 8] = r_wdata[n*8 +: 8];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state   = r_state;
    w_lcount  = r_lcount;
    w_cs_b    = r_cs_b;
    w_oe_b    = r_oe_b;
    w_wr_b    = r_wr_b;
    w_addr    = r_addr;
    w_dq_out  = r_dq_out;
    w_dq_oe   = r_dq_oe;
    w_a_ready = 1'b0;
    w_b_ready = 1'b0;
    w_a_rdata = r_a_rdata;
    w_b_rdata = r_b_rdata;
    w_grant_b = r_grant_b;
    w_be      = r_be;
    w_wdata   = r_wdata;

    case (r_state)
      S_IDLE: begin
        if (w_a_req | w_b_req) begin
          w_grant_b = w_win_b;
          w_be      = w_sel_be;
          w_wdata   = w_sel_wdata;
          if (w_sel_rd) begin
            w_addr   = w_sel_addr;
            w_cs_b   = 1'b0;
            w_oe_b   = 1'b0;
            w_dq_oe  = 1'b0;
            w_lcount = CNT_W'(RD_LAT);
            w_state  = S_READ;
          end else if (w_sel_be == 4'b1111) begin
            w_addr   = w_sel_addr;
            w_cs_b   = 1'b0;
            w_wr_b   = 1'b0;
            w_dq_out = w_sel_wdata;
            w_dq_oe  = 1'b1;
            w_lcount = CNT_W'(WR_LAT);
            w_state  = S_WRITE;
          end else if (w_sel_be == 4'b0000) begin
            // Nothing to write: complete without touching the SRAM
            w_a_ready = ~w_win_b;
            w_b_ready = w_win_b;
            w_state   = S_DONE;
          end else begin
            w_addr   = w_sel_addr;
            w_cs_b   = 1'b0;
            w_oe_b   = 1'b0;
            w_dq_oe  = 1'b0;
            w_lcount = CNT_W'(RMW_RD_LAT);
            w_state  = S_RMW_RD;
          end
        end
      end

      S_READ: begin
        if (r_lcount != '0) begin
          w_lcount = r_lcount - CNT_W'(1);
        end else begin
          if (r_grant_b) w_b_rdata = bus.ram_dq_in;
          else           w_a_rdata = bus.ram_dq_in;
          w_cs_b    = 1'b1;
          w_oe_b    = 1'b1;
          w_a_ready = ~r_grant_b;
          w_b_ready = r_grant_b;
          w_state   = S_DONE;
        end
      end

      S_RMW_RD: begin
        if (r_lcount != '0) begin
          w_lcount = r_lcount - CNT_W'(1);
        end else begin
          // OE releases on the same edge WR asserts, so they never overlap
          w_dq_out = w_merge;
          w_oe_b   = 1'b1;
          w_wr_b   = 1'b0;
          w_dq_oe  = 1'b1;
          w_lcount = CNT_W'(RMW_WR_LAT);
          w_state  = S_WRITE;
        end
      end

      S_WRITE: begin
        if (r_lcount != '0) begin
          w_lcount = r_lcount - CNT_W'(1);
        end else begin
          w_cs_b    = 1'b1;
          w_oe_b    = 1'b1;
          w_wr_b    = 1'b1;
          w_dq_oe   = 1'b0;
          w_a_ready = ~r_grant_b;
          w_b_ready = r_grant_b;
          w_state   = S_DONE;
        end
      end

      S_DONE: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign bus.a_rdata    = r_a_rdata;
  assign bus.a_ready    = r_a_ready;
  assign bus.b_rdata    = r_b_rdata;
  assign bus.b_ready    = r_b_ready;
  assign bus.grant_b    = r_grant_b;
  assign bus.ram_cs_b   = r_cs_b;
  assign bus.ram_oe_b   = r_oe_b;
  assign bus.ram_wr_b   = r_wr_b;
  assign bus.ram_addr   = r_addr;
  assign bus.ram_dq_out = r_dq_out;
  assign bus.ram_dq_oe  = r_dq_oe;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small behavioural SRAM on the pads.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst_b;

  sram_arbiter_if sif ();

  sram_arbiter #(
    .RD_LAT    (1),
    .WR_LAT    (1),
    .RMW_RD_LAT(1),
    .RMW_WR_LAT(1)
  ) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (sif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // SRAM model: 256 words aliased on the low address byte
  logic [31:0] mem [256];
  int          wr_count   = 0;
  int          oe_wr_both = 0;
  int          dq_oe_bad  = 0;
  int          both_ready = 0;
  bit          wr_prev    = 1'b1;

  assign sif.ram_dq_in = (!sif.ram_cs_b && !sif.ram_oe_b) ? mem[sif.ram_addr[7:0]] : 32'h0;

  always @(negedge clk) begin
    if (!sif.ram_cs_b && !sif.ram_wr_b && sif.ram_dq_oe)
      mem[sif.ram_addr[7:0]] = sif.ram_dq_out;
    if (!sif.ram_wr_b && wr_prev) wr_count++;
    wr_prev = sif.ram_wr_b;
    if (!sif.ram_wr_b && !sif.ram_oe_b) oe_wr_both++;
    if (sif.ram_dq_oe && sif.ram_wr_b) dq_oe_bad++;
    if (sif.a_ready && sif.b_ready) both_ready++;
  end

  typedef struct {
    bit          pb;
    bit          rd;
    bit          wr;
    logic [18:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          pre;
    logic [31:0] pre_val;
    logic [31:0] exp_rdata;
    logic [31:0] exp_mem;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit pb, input bit rd, input bit wr, input logic [18:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
    if (pb) begin
      sif.b_rd = rd; sif.b_wr = wr; sif.b_addr = addr; sif.b_be = be; sif.b_wdata = wdata;
    end else begin
      sif.a_rd = rd; sif.a_wr = wr; sif.a_addr = addr; sif.a_be = be; sif.a_wdata = wdata;
    end
  endtask

  // Issue one request in IDLE; latency counts edges from applying it until ready is seen
  task automatic issue(input vec_t v, output int lat, output logic [31:0] rdata,
                       output bit seen, output bit other);
    @(negedge clk);
    @(negedge clk);
    set_req(v.pb, v.rd, v.wr, v.addr, v.be, v.wdata);
    lat = 0; seen = 1'b0; other = 1'b0; rdata = '0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (v.pb ? sif.a_ready : sif.b_ready) other = 1'b1;
      if (v.pb ? sif.b_ready : sif.a_ready) begin
        seen  = 1'b1;
        lat   = c;
        rdata = v.pb ? sif.b_rdata : sif.a_rdata;
        set_req(v.pb, 1'b0, 1'b0, v.addr, v.be, v.wdata);
      end
    end
    if (!seen) set_req(v.pb, 1'b0, 1'b0, v.addr, v.be, v.wdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rdata;
    bit          seen;
    bit          other;
    int          wc0;
    int          n;
    int          width_bad;
    bit          order [4];
    bit          grants [4];
    bit          prev_a;
    bit          prev_b;
    bit          a_seen;

    //           pb rd wr addr       be       wdata         pre pre_val       exp_rdata     exp_mem       lat wr
    vecs[0] = '{0, 1, 0, 19'h00010, 4'b0000, 32'h0,        1,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3, 0};
    vecs[1] = '{1, 0, 1, 19'h7FFFF, 4'b1111, 32'h11223344, 1,  32'h0,        32'h0,        32'h11223344, 3, 1};
    vecs[2] = '{1, 1, 0, 19'h7FFFF, 4'b0000, 32'h0,        0,  32'h0,        32'h11223344, 32'h11223344, 3, 0};
    vecs[3] = '{0, 0, 1, 19'h00020, 4'b0101, 32'h00550066, 1,  32'hAABBCCDD, 32'h0,        32'hAA55CC66, 5, 1};
    vecs[4] = '{1, 0, 1, 19'h00030, 4'b0000, 32'hFFFFFFFF, 1,  32'h12345678, 32'h0,        32'h12345678, 1, 0};
    vecs[5] = '{0, 1, 1, 19'h00040, 4'b1111, 32'h0,        1,  32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 3, 0};
    vecs[6] = '{1, 0, 1, 19'h00050, 4'b1000, 32'hAB000000, 1,  32'h01020304, 32'h0,        32'hAB020304, 5, 1};
    vecs[7] = '{0, 1, 0, 19'h00050, 4'b0000, 32'h0,        0,  32'h0,        32'hAB020304, 32'hAB020304, 3, 0};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    set_req(1'b0, 1'b0, 1'b0, 19'h0, 4'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 19'h0, 4'h0, 32'h0);
    rst_b = 1'b0;

    // Reset values
    #22;
    check("rst_cs_b",    32'(sif.ram_cs_b),   32'h1);
    check("rst_oe_b",    32'(sif.ram_oe_b),   32'h1);
    check("rst_wr_b",    32'(sif.ram_wr_b),   32'h1);
    check("rst_dq_oe",   32'(sif.ram_dq_oe),  32'h0);
    check("rst_addr",    32'(sif.ram_addr),   32'h0);
    check("rst_dq_out",  sif.ram_dq_out,      32'h0);
    check("rst_a_ready", 32'(sif.a_ready),    32'h0);
    check("rst_b_ready", 32'(sif.b_ready),    32'h0);
    check("rst_a_rdata", sif.a_rdata,         32'h0);
    check("rst_grant_b", 32'(sif.grant_b),    32'h1);

    // Reset asserted in the middle of a port A read
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    mem[8'h10] = 32'hDEADBEEF;
    set_req(1'b0, 1'b1, 1'b0, 19'h00010, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    check("midrst_accepted_cs_b", 32'(sif.ram_cs_b), 32'h0);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("midrst_cs_b",  32'(sif.ram_cs_b),  32'h1);
    check("midrst_oe_b",  32'(sif.ram_oe_b),  32'h1);
    check("midrst_dq_oe", 32'(sif.ram_dq_oe), 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("midrst_no_a_ready_%0d", c), 32'(sif.a_ready), 32'h0);
    end
    @(negedge clk);
    rst_b = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 19'h00010, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    check("postrst_no_a_ready", 32'(sif.a_ready), 32'h0);

    // Contention from reset: both ports read continuously, grants alternate A,B,A,B
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b0, 19'h00010, 4'h0, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 19'h7FFFF, 4'h0, 32'h0);
    n = 0; width_bad = 0; prev_a = 1'b0; prev_b = 1'b0;
    for (int c = 0; c < 80 && n < 4; c++) begin
      @(posedge clk);
      #1;
      if ((sif.a_ready && prev_a) || (sif.b_ready && prev_b)) width_bad++;
      prev_a = sif.a_ready;
      prev_b = sif.b_ready;
      if (sif.a_ready) begin order[n] = 1'b0; grants[n] = sif.grant_b; n++; end
      else if (sif.b_ready) begin order[n] = 1'b1; grants[n] = sif.grant_b; n++; end
    end
    set_req(1'b0, 1'b0, 1'b0, 19'h0, 4'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 19'h0, 4'h0, 32'h0);
    check("cont_ready_count", 32'(n), 32'd4);
    for (int k = 0; k < n; k++) begin
      check($sformatf("cont_order_%0d", k), 32'(order[k]),  32'(k % 2));
      check($sformatf("cont_grant_%0d", k), 32'(grants[k]), 32'(k % 2));
    end
    check("cont_ready_width", 32'(width_bad), 32'h0);

    // Table-driven single transactions
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].pre) mem[vecs[i].addr[7:0]] = vecs[i].pre_val;
      wc0 = wr_count;
      issue(vecs[i], lat, rdata, seen, other);
      check($sformatf("v%0d_ready_seen", i), 32'(seen), 32'h1);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_other_ready", i), 32'(other), 32'h0);
      check($sformatf("v%0d_grant_b", i), 32'(sif.grant_b), 32'(vecs[i].pb));
      if (vecs[i].rd) check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_mem", i), mem[vecs[i].addr[7:0]], vecs[i].exp_mem);
      check($sformatf("v%0d_sram_writes", i), 32'(wr_count - wc0), 32'(vecs[i].exp_wr));
    end
    check("b_rdata_held", sif.b_rdata, 32'h11223344);

    // Request dropped right after accept of an RMW: the write still completes
    mem[8'h60] = 32'h11111111;
    @(negedge clk);
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b1, 19'h00060, 4'b0011, 32'h22222222);
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b0, 19'h00000, 4'b0000, 32'h0);
    a_seen = 1'b0;
    for (int c = 0; c < 40 && !a_seen; c++) begin
      @(posedge clk);
      #1;
      if (sif.a_ready) a_seen = 1'b1;
    end
    check("drop_rmw_ready", 32'(a_seen), 32'h1);
    check("drop_rmw_mem", mem[8'h60], 32'h11112222);
    check("drop_rmw_addr_held", 32'(sif.ram_addr), 32'h00060);

    // Strobe invariants over the whole run
    check("never_oe_and_wr", 32'(oe_wr_both), 32'h0);
    check("dq_oe_only_write", 32'(dq_oe_bad), 32'h0);
    check("never_both_ready", 32'(both_ready), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
